// File: rtl/adder_share_pkg.sv
// Shared types and helpers for controllers that multiplex one adder between clients.
package adder_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 12;
    localparam int DEF_N_REQ = 4;
    localparam int MAX_WIDTH = 32;

    // Adder bus layout: even bits carry A, odd bits carry B; callers truncate to 2*WIDTH.
    function automatic logic [2*MAX_WIDTH-1:0] interleave(
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b
    );
        logic [2*MAX_WIDTH-1:0] bus;
        bus = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            bus[2*i]   = a[i];
            bus[2*i+1] = b[i];
        end
        return bus;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             valid_o
);

    logic [2*N_REQ-1:0] req2_s;
    logic               hit_s;

    assign req2_s = {req_i, req_i};

    // Scan the doubled request vector inside the window [ptr, ptr+N_REQ) so wrap needs no modulo on the index.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        hit_s   = 1'b0;
        for (int j = 0; j < 2*N_REQ; j++) begin
            hit_s = en_i && !valid_o && req2_s[j]
                    && (j >= int'(ptr_i)) && (j < int'(ptr_i) + N_REQ);
            grant_o[j % N_REQ] = grant_o[j % N_REQ] | hit_s;
            idx_o   = hit_s ? ID_W'(j % N_REQ) : idx_o;
            valid_o = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Time-shares one external combinational adder between N_REQ clients with
// round-robin grant; operands and sum are both registered around the adder.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ADD_LAT = 1,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [WIDTH:0]         resp_sum,
    output logic [2*WIDTH-1:0]     add_in,
    input  logic [WIDTH:0]         add_out,
    output logic                   busy
);

    localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ADD_LAT - 1);

    state_t             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic [2*WIDTH-1:0] add_in_q;
    logic [ID_W-1:0]    id_q;
    logic               resp_valid_q;
    logic [ID_W-1:0]    resp_id_q;
    logic [WIDTH:0]     resp_sum_q;
    logic               busy_q;

    logic               arb_en_s;
    logic [N_REQ-1:0]   grant_s;
    logic [ID_W-1:0]    gnt_idx_s;
    logic               gnt_vld_s;
    logic [WIDTH-1:0]   sel_a_s;
    logic [WIDTH-1:0]   sel_b_s;
    logic [2*WIDTH-1:0] ilv_s;

    // Grants are suppressed while reset is held so req_ready reads 0 during reset.
    assign arb_en_s = (state_q == IDLE) && !rst;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .en_i    (arb_en_s),
        .grant_o (grant_s),
        .idx_o   (gnt_idx_s),
        .valid_o (gnt_vld_s)
    );

    // One-hot operand mux driven by the grant vector.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sel_a_s = sel_a_s | (req_a[k*WIDTH +: WIDTH] & {WIDTH{grant_s[k]}});
            sel_b_s = sel_b_s | (req_b[k*WIDTH +: WIDTH] & {WIDTH{grant_s[k]}});
        end
    end

    assign ilv_s = (2*WIDTH)'(interleave(MAX_WIDTH'(sel_a_s), MAX_WIDTH'(sel_b_s)));

    // Pointer moves just past the winner, so it drops to lowest priority.
    always_comb begin
        if (int'(gnt_idx_s) == N_REQ - 1) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = gnt_idx_s + ID_W'(1);
        end
    end

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            wait_cnt_q   <= '0;
            add_in_q     <= '0;
            id_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_vld_s) begin
                        add_in_q   <= ilv_s;
                        id_q       <= gnt_idx_s;
                        rr_ptr_q   <= rr_ptr_d;
                        wait_cnt_q <= CNT_INIT;
                        state_q    <= WAIT;
                        busy_q     <= 1'b1;
                    end else begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                    end
                end
                WAIT: begin
                    if (wait_cnt_q == '0) begin
                        resp_sum_q   <= add_out;
                        resp_id_q    <= id_q;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        wait_cnt_q   <= wait_cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                        busy_q       <= 1'b0;
                    end else begin
                        state_q      <= RESP;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = grant_s;
    assign add_in     = add_in_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_sum   = resp_sum_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench: two DUT copies (ADD_LAT=1 and ADD_LAT=3) driven by the same program,
// each checked against a transaction-level round-robin / latency model.
module tb_adder_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 12;
    localparam int IDW = 2;

    typedef struct {
        int             id;
        logic [W:0]     sum;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic logic [2*W-1:0] ilv(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] r;
        for (int i = 0; i < W; i++) begin
            r[2*i]   = a[i];
            r[2*i+1] = b[i];
        end
        return r;
    endfunction

    function automatic logic [W:0] bus_sum(input logic [2*W-1:0] bus);
        logic [W-1:0] a;
        logic [W-1:0] b;
        for (int i = 0; i < W; i++) begin
            a[i] = bus[2*i];
            b[i] = bus[2*i+1];
        end
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        case ($urandom_range(7))
            0: v = {W{1'b1}};
            1: v = '0;
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic             rst;
        logic [N-1:0]     req_valid;
        logic [N-1:0]     req_ready;
        logic [N*W-1:0]   req_a;
        logic [N*W-1:0]   req_b;
        logic             resp_valid;
        logic             resp_ready;
        logic [IDW-1:0]   resp_id;
        logic [W:0]       resp_sum;
        logic [2*W-1:0]   add_in;
        logic [W:0]       add_out;
        logic             busy;

        int               xcnt = 0;
        logic [2*W-1:0]   last_in = '0;
        exp_t             q[$];
        bit               pend [N];
        logic [W-1:0]     pa [N];
        logic [W-1:0]     pb [N];
        int               rr, gcyc, cyc, p_req, p_rdy;
        bit               free;
        bit               done = 1'b0;
        logic [W-1:0]     la, lb;

        adder_share_arbiter #(
            .N_REQ   (N),
            .WIDTH   (W),
            .ADD_LAT (LAT)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .req_valid  (req_valid),
            .req_ready  (req_ready),
            .req_a      (req_a),
            .req_b      (req_b),
            .resp_valid (resp_valid),
            .resp_ready (resp_ready),
            .resp_id    (resp_id),
            .resp_sum   (resp_sum),
            .add_in     (add_in),
            .add_out    (add_out),
            .busy       (busy)
        );

        // Adder model: result is unknown for LAT-1 cycles after its inputs change.
        assign add_out = (xcnt > 0) ? {(W+1){1'bx}} : bus_sum(add_in);

        always @(posedge clk) begin
            #1;
            if (add_in !== last_in) begin
                last_in = add_in;
                xcnt    = LAT - 1;
            end else if (xcnt > 0) begin
                xcnt = xcnt - 1;
            end
        end

        // Monitor: every presented response must match the oldest outstanding grant.
        always @(negedge clk) begin
            if (rst === 1'b0 && resp_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL L%0d unexpected_resp: got id=%0d sum=%0h, required no response",
                             g, resp_id, resp_sum);
                end else begin
                    check($sformatf("L%0d resp_id", g), 64'(resp_id), 64'(q[0].id));
                    check($sformatf("L%0d resp_sum", g), 64'(resp_sum), 64'(q[0].sum));
                    if (resp_ready) void'(q.pop_front());
                end
            end
        end

        task automatic drive();
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && int'($urandom_range(99)) < p_req) begin
                    pend[k] = 1'b1;
                    pa[k]   = rnd_op();
                    pb[k]   = rnd_op();
                end
                req_valid[k]       = pend[k];
                req_a[k*W +: W]    = pa[k];
                req_b[k*W +: W]    = pb[k];
            end
            resp_ready = (int'($urandom_range(99)) < p_rdy);
        endtask

        task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
            pend[k]         = 1'b1;
            pa[k]           = a;
            pb[k]           = b;
            req_valid[k]    = 1'b1;
            req_a[k*W +: W] = a;
            req_b[k*W +: W] = b;
        endtask

        task automatic cycle();
            logic [N-1:0] er;
            int           gk;
            bit           ev;
            exp_t         e;
            @(negedge clk);
            cyc++;
            er = '0;
            gk = -1;
            if (free) begin
                for (int i = 0; i < N; i++) begin
                    if (gk < 0 && pend[(rr + i) % N]) gk = (rr + i) % N;
                end
            end
            if (gk >= 0) er[gk] = 1'b1;
            ev = !free && (cyc - gcyc > LAT);
            check($sformatf("L%0d req_ready", g), 64'(req_ready), 64'(er));
            check($sformatf("L%0d resp_valid", g), 64'(resp_valid), 64'(ev));
            check($sformatf("L%0d busy", g), 64'(busy), 64'(!free));
            check($sformatf("L%0d add_in", g), 64'(add_in), 64'(ilv(la, lb)));
            if (gk >= 0) begin
                e.id  = gk;
                e.sum = {1'b0, pa[gk]} + {1'b0, pb[gk]};
                q.push_back(e);
                la       = pa[gk];
                lb       = pb[gk];
                pend[gk] = 1'b0;
                free     = 1'b0;
                gcyc     = cyc;
                rr       = (gk + 1) % N;
            end else if (ev && resp_ready) begin
                free = 1'b1;
            end
            @(posedge clk);
            #1;
            drive();
        endtask

        task automatic run(input int n);
            for (int i = 0; i < n; i++) cycle();
        endtask

        task automatic do_reset();
            rst        = 1'b1;
            req_valid  = '0;
            resp_ready = 1'b0;
            for (int k = 0; k < N; k++) pend[k] = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check($sformatf("L%0d rst_req_ready", g), 64'(req_ready), 64'(0));
            check($sformatf("L%0d rst_resp_valid", g), 64'(resp_valid), 64'(0));
            check($sformatf("L%0d rst_resp_id", g), 64'(resp_id), 64'(0));
            check($sformatf("L%0d rst_resp_sum", g), 64'(resp_sum), 64'(0));
            check($sformatf("L%0d rst_add_in", g), 64'(add_in), 64'(0));
            check($sformatf("L%0d rst_busy", g), 64'(busy), 64'(0));
            q.delete();
            free = 1'b1;
            rr   = 0;
            cyc  = 0;
            gcyc = 0;
            la   = '0;
            lb   = '0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            drive();
        endtask

        initial begin
            rst        = 1'b1;
            req_valid  = '0;
            req_a      = '0;
            req_b      = '0;
            resp_ready = 1'b0;
            p_req      = 0;
            p_rdy      = 100;
            for (int k = 0; k < N; k++) begin
                pend[k] = 1'b0;
                pa[k]   = '0;
                pb[k]   = '0;
            end
            do_reset();

            set_req(0, 12'h123, 12'h456);
            run(LAT + 5);
            set_req(1, 12'hFFF, 12'h001);
            run(LAT + 5);
            set_req(2, 12'hFFF, 12'hFFF);
            run(LAT + 5);

            // All requesters held from reset; immediate reassertion gives the wrap back to 0.
            do_reset();
            for (int k = 0; k < N; k++) set_req(k, rnd_op(), rnd_op());
            p_req = 100;
            run(5 * (LAT + 2));
            p_req = 0;
            run(5 * (LAT + 2) + 4);

            // Back-pressure with a competing requester waiting.
            p_rdy = 0;
            set_req(3, rnd_op(), rnd_op());
            set_req(1, rnd_op(), rnd_op());
            run(LAT + 7);
            p_rdy = 100;
            run(3 * (LAT + 2) + 4);

            // Abort in WAIT after granting requester 1; pointer must return to 0.
            set_req(1, rnd_op(), rnd_op());
            cycle();
            do_reset();
            set_req(0, rnd_op(), rnd_op());
            set_req(2, rnd_op(), rnd_op());
            run(3 * (LAT + 2) + 4);

            p_req = 30;
            p_rdy = 60;
            run(500);
            p_req = 0;
            p_rdy = 100;
            run(40);
            check($sformatf("L%0d drain_queue", g), 64'(q.size()), 64'(0));
            for (int k = 0; k < N; k++) begin
                check($sformatf("L%0d drain_pend%0d", g, k), 64'(pend[k]), 64'(0));
            end
            done = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(lane[0].done && lane[1].done) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (!(lane[0].done && lane[1].done)) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d cycles without completion, required completion", t);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
